// File: rtl/pixel_stream_source_pkg.sv
// Shared definitions for the pixel stream source: default geometry, FSM
// state encoding and the packed pixel width helper.
package pixel_stream_source_pkg;

  localparam int DEFAULT_I_WIDTH      = 8;
  localparam int DEFAULT_CHANNELS_IN  = 3;
  localparam int DEFAULT_IMAGE_WIDTH  = 64;
  localparam int DEFAULT_IMAGE_HEIGHT = 32;
  localparam int DEFAULT_ADDR_WIDTH   = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Packed pixel width: all channels side by side, channel 0 in the LSBs.
  function automatic int pixel_width(input int i_width, input int channels);
    return i_width * channels;
  endfunction

endpackage

// File: rtl/pixel_stream_source_frame_buffer_ram.sv
// Frame buffer: one write port, one synchronous read port with read enable.
// The read register resets to zero and holds its value when rd_en is low.
module frame_buffer_ram #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first: a same-edge read of the address being written sees the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (we && (wr_addr == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Frame-buffered image streamer: a host loads one raster-order frame, then
// start plays it out one pixel per non-paused cycle with row/col coordinates.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int I_WIDTH      = DEFAULT_I_WIDTH,
  parameter int CHANNELS_IN  = DEFAULT_CHANNELS_IN,
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [I_WIDTH*CHANNELS_IN-1:0]    wr_data,
  input  logic                              start,
  input  logic                              pause,
  output logic                              stream_en,
  output logic [I_WIDTH*CHANNELS_IN-1:0]    pixel_data,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]   row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]    col,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int PIX_W   = pixel_width(I_WIDTH, CHANNELS_IN);
  localparam int NUM_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int ROW_W   = $clog2(IMAGE_HEIGHT);
  localparam int COL_W   = $clog2(IMAGE_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_PIX - 1);
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(IMAGE_WIDTH - 1);

  state_e state, state_next;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ROW_W-1:0]      ptr_row;
  logic [COL_W-1:0]      ptr_col;
  logic                  advance;
  logic                  launch;
  logic                  addr_ok;
  logic                  wr_accept;

  // Addresses past the frame are dropped; the check vanishes when the frame fills the address space.
  if ((2 ** ADDR_WIDTH) > NUM_PIX) begin : g_addr_chk
    assign addr_ok = (wr_addr <= LAST_PTR);
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  assign wr_accept = wr_en && (state == ST_IDLE) && addr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    launch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!pause) begin
          advance = 1'b1;
          if (ptr == LAST_PTR) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ptr, ptr_row and ptr_col step together so coordinates need no divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      ptr_row    <= '0;
      ptr_col    <= '0;
      row        <= '0;
      col        <= '0;
      stream_en  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      stream_en  <= advance;
      frame_done <= (state == ST_DONE);
      if (launch) begin
        busy <= 1'b1;
      end else if (state == ST_DONE) begin
        busy <= 1'b0;
      end
      if (launch) begin
        ptr     <= '0;
        ptr_row <= '0;
        ptr_col <= '0;
      end else if (advance) begin
        row <= ptr_row;
        col <= ptr_col;
        ptr <= ptr + 1'b1;
        if (ptr_col == LAST_COL) begin
          ptr_col <= '0;
          ptr_row <= ptr_row + 1'b1;
        end else begin
          ptr_col <= ptr_col + 1'b1;
        end
      end
    end
  end

  frame_buffer_ram #(
    .WIDTH      (PIX_W),
    .DEPTH      (NUM_PIX),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_frame_buffer_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (advance),
    .rd_addr (ptr),
    .rd_data (pixel_data)
  );

endmodule
